// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, FSM state type and GF(2^8) helpers for the AES decrypt engine
package aes_pkg;

   localparam int AES_BLOCK  = 128;
   localparam int MAX_ROUNDS = 14;

   // Legal key-size / key-word / round-count triples
   localparam int WIDTH_128 = 128;
   localparam int NK_128    = 4;
   localparam int NR_128    = 10;
   localparam int WIDTH_192 = 192;
   localparam int NK_192    = 6;
   localparam int NR_192    = 12;
   localparam int WIDTH_256 = 256;
   localparam int NK_256    = 8;
   localparam int NR_256    = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } dec_state_t;

   function automatic logic legal_cfg(input int width, input int nk, input int nr);
      return ((width == WIDTH_128) && (nk == NK_128) && (nr == NR_128)) ||
             ((width == WIDTH_192) && (nk == NK_192) && (nr == NR_192)) ||
             ((width == WIDTH_256) && (nk == NK_256) && (nr == NR_256));
   endfunction

   // Round key k of the decryption-ordered schedule; callers zero-pad to the 14-round size
   function automatic logic [AES_BLOCK-1:0] round_key_slice(
      input logic [AES_BLOCK*(MAX_ROUNDS+1)-1:0] word,
      input logic [3:0]                          k
   );
      return word[AES_BLOCK*k +: AES_BLOCK];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); zero maps to zero as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(a, a);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Inverse S-box: undo the affine map, then invert in GF(2^8)
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = 8'h00;
      for (int i = 0; i < 8; i++) begin
         t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
      end
      return gf_inv(t ^ 8'h05);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [AES_BLOCK-1:0] state_in,
   input  logic [AES_BLOCK-1:0] round_key,
   input  logic                 last_round,
   output logic [AES_BLOCK-1:0] state_out
);

   logic [AES_BLOCK-1:0] shifted;
   logic [AES_BLOCK-1:0] subbed;
   logic [AES_BLOCK-1:0] keyed;
   logic [AES_BLOCK-1:0] mixed;

   // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4; row r rotates right by r
   function automatic logic [AES_BLOCK-1:0] inv_shift_row(input logic [AES_BLOCK-1:0] s);
      logic [AES_BLOCK-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[AES_BLOCK-1-8*(r+4*c) -: 8] = s[AES_BLOCK-1-8*(r+4*((c-r+4)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [AES_BLOCK-1:0] inv_sub_bytes(input logic [AES_BLOCK-1:0] s);
      logic [AES_BLOCK-1:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[AES_BLOCK-1-8*i -: 8] = inv_sbox(s[AES_BLOCK-1-8*i -: 8]);
      end
      return o;
   endfunction

   function automatic logic [AES_BLOCK-1:0] add_round_key(input logic [AES_BLOCK-1:0] s,
                                                          input logic [AES_BLOCK-1:0] k);
      return s ^ k;
   endfunction

   function automatic logic [AES_BLOCK-1:0] inv_mix_colume(input logic [AES_BLOCK-1:0] s);
      logic [AES_BLOCK-1:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[AES_BLOCK-1-32*c  -: 8];
         a1 = s[AES_BLOCK-9-32*c  -: 8];
         a2 = s[AES_BLOCK-17-32*c -: 8];
         a3 = s[AES_BLOCK-25-32*c -: 8];
         o[AES_BLOCK-1-32*c  -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[AES_BLOCK-9-32*c  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[AES_BLOCK-17-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[AES_BLOCK-25-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // One inverse round; the final round skips InvMixColumns
   always_comb begin
      shifted   = inv_shift_row(state_in);
      subbed    = inv_sub_bytes(shifted);
      keyed     = add_round_key(subbed, round_key);
      mixed     = inv_mix_colume(keyed);
      state_out = last_round ? keyed : mixed;
   end

endmodule

// File: rtl/aes_decrypt_iter_ctrl.sv
// rtl/aes_decrypt_iter_ctrl.sv - iterative AES inverse-cipher controller, one round per cycle
module aes_decrypt_iter_ctrl
   import aes_pkg::*;
#(
   parameter int Width = 128,
   parameter int Nk    = 4,
   parameter int Nr    = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [AES_BLOCK-1:0]        in_data,
   input  logic [Width-1:0]            in_key,
   output logic [Width-1:0]            key_q,
   input  logic [AES_BLOCK*(Nr+1)-1:0] word_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [AES_BLOCK-1:0]        out_data,
   input  logic                        flush,
   output logic                        busy,
   output logic [3:0]                  round_cnt
);

   // round_cnt is fixed at 4 bits, so larger round counts cannot be represented
   if ((Nr > MAX_ROUNDS) || !legal_cfg(Width, Nk, Nr)) begin : g_bad_cfg
      $error("aes_decrypt_iter_ctrl: unsupported Width/Nk/Nr combination");
   end

   localparam logic [3:0] NR_L = 4'(Nr);

   dec_state_t fsm_q, fsm_d;
   logic [AES_BLOCK-1:0] data_q, data_d;
   logic [AES_BLOCK-1:0] state_q, state_d;
   logic [Width-1:0]     key_d;
   logic [3:0]           round_q, round_d;
   logic [AES_BLOCK-1:0] round_out;
   logic [AES_BLOCK-1:0] cur_key;
   logic                 last_round;
   logic                 accept;

   logic [AES_BLOCK*(MAX_ROUNDS+1)-1:0] word_pad;

   // Widen the round-key bus to the 14-round size so one slice helper serves every key length
   always_comb begin
      word_pad = '0;
      word_pad[AES_BLOCK*(Nr+1)-1:0] = word_in;
   end

   assign cur_key    = round_key_slice(word_pad, (fsm_q == LOAD) ? 4'd0 : round_q);
   assign last_round = (round_q == NR_L);
   assign accept     = in_valid && in_ready;

   aes_inv_round u_round (
      .state_in   (state_q),
      .round_key  (cur_key),
      .last_round (last_round),
      .state_out  (round_out)
   );

   assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == LOAD) || (fsm_q == ROUND);
   assign out_data  = state_q;
   assign round_cnt = round_q;

   // Next-state logic; flush overrides every transition and freezes the datapath registers
   always_comb begin
      fsm_d   = fsm_q;
      data_d  = data_q;
      key_d   = key_q;
      state_d = state_q;
      round_d = round_q;
      case (fsm_q)
         IDLE: begin
            if (accept) begin
               data_d = in_data;
               key_d  = in_key;
               fsm_d  = LOAD;
            end
         end
         LOAD: begin
            // key_q was latched last cycle, so word_in now reflects the new schedule
            state_d = data_q ^ cur_key;
            round_d = 4'd1;
            fsm_d   = ROUND;
         end
         ROUND: begin
            state_d = round_out;
            if (last_round) begin
               fsm_d = DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               round_d = 4'd0;
               if (in_valid) begin
                  data_d = in_data;
                  key_d  = in_key;
                  fsm_d  = LOAD;
               end else begin
                  fsm_d = IDLE;
               end
            end
         end
         default: begin
            fsm_d   = IDLE;
            round_d = 4'd0;
         end
      endcase
      if (flush) begin
         fsm_d   = IDLE;
         round_d = 4'd0;
         data_d  = data_q;
         key_d   = key_q;
         state_d = state_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         data_q  <= '0;
         key_q   <= '0;
         state_q <= '0;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         data_q  <= data_d;
         key_q   <= key_d;
         state_q <= state_d;
         round_q <= round_d;
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter_ctrl.sv
// tb/tb_aes_decrypt_iter_ctrl.sv - scoreboard bench for the iterative AES decrypt controller
module tb_aes_decrypt_iter_ctrl;

   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0, flush0 = 1'b0, busy0;
   logic [127:0]   in_data0 = '0, in_key0 = '0, key_q0, out_data0;
   logic [3:0]     round_cnt0;
   logic [128*11-1:0] word_in0;
   logic [128*15-1:0] sched0;

   logic           in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, flush1 = 1'b0, busy1;
   logic [127:0]   in_data1 = '0, out_data1;
   logic [255:0]   in_key1 = '0, key_q1;
   logic [3:0]     round_cnt1;
   logic [128*15-1:0] word_in1;

   int vectors = 0;
   int miscompares = 0;
   logic [127:0] exp0_q[$];
   logic [127:0] exp1_q[$];

   function automatic logic [7:0] tb_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= t;
         t = tb_xtime(t);
      end
      return p;
   endfunction

   // Forward S-box: inverse found by exhaustive search, then the FIPS-197 affine map
   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] x = 8'h00;
      logic [7:0] s = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (tb_mul(a, 8'(y)) == 8'h01) x = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
         s[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {fwd_sbox(w[31:24]), fwd_sbox(w[23:16]), fwd_sbox(w[15:8]), fwd_sbox(w[7:0])};
   endfunction

   // Key_Expansion model; slice k holds round key nr-k (decryption order)
   function automatic logic [128*15-1:0] key_expand(input logic [255:0] key, input int nk, input int nr);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0] rcon = 8'h01;
      logic [128*15-1:0] res = '0;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = tb_xtime(rcon);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k <= nr; k++) begin
         res[128*k +: 128] = {w[4*(nr-k)], w[4*(nr-k)+1], w[4*(nr-k)+2], w[4*(nr-k)+3]};
      end
      return res;
   endfunction

   always_comb sched0 = key_expand({key_q0, 128'h0}, 4, 10);
   assign word_in0 = sched0[128*11-1:0];
   always_comb word_in1 = key_expand(key_q1, 8, 14);

   aes_decrypt_iter_ctrl #(.Width(128), .Nk(4), .Nr(10)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_data(in_data0), .in_key(in_key0), .key_q(key_q0), .word_in(word_in0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .flush(flush0), .busy(busy0), .round_cnt(round_cnt0)
   );

   aes_decrypt_iter_ctrl #(.Width(256), .Nk(8), .Nr(14)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .in_key(in_key1), .key_q(key_q1), .word_in(word_in1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .flush(flush1), .busy(busy1), .round_cnt(round_cnt1)
   );

   task automatic test_reset();
      @(negedge clk);
      vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
      vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy0); end
      vectors++; if (round_cnt0 !== 4'd0) begin miscompares++; $display("FAIL reset_round_cnt: got %0d want 0", round_cnt0); end
      vectors++; if (out_data0 !== 128'h0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data0); end
      vectors++; if (key_q0 !== 128'h0) begin miscompares++; $display("FAIL reset_key_q: got %h want 0", key_q0); end
      vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid_nr14: got %b want 0", out_valid1); end
      rst_n = 1'b1;
   endtask

   task automatic test_fips_c1();
      int lat;
      logic [127:0] exp;
      @(negedge clk);
      in_data0 = C1_CT; in_key0 = C1_KEY; in_valid0 = 1'b1; out_ready0 = 1'b1;
      exp0_q.push_back(C1_PT);
      vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL c1_in_ready: got %b want 1", in_ready0); end
      @(posedge clk); #1; in_valid0 = 1'b0;
      lat = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); lat++;
         if (lat == 1) begin
            vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL c1_busy_load: got %b want 1", busy0); end
         end
         if (out_valid0 === 1'b1) break;
      end
      vectors++; if (lat !== 12) begin miscompares++; $display("FAIL c1_latency: got %0d want 12", lat); end
      if (out_valid0 === 1'b1 && exp0_q.size() > 0) begin
         exp = exp0_q.pop_front();
         vectors++; if (out_data0 !== exp) begin miscompares++; $display("FAIL c1_plaintext: got %h want %h", out_data0, exp); end
      end
      exp0_q.delete();
      @(negedge clk);
      vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL c1_valid_drop: got %b want 0", out_valid0); end
      vectors++; if (round_cnt0 !== 4'd0) begin miscompares++; $display("FAIL c1_round_clear: got %0d want 0", round_cnt0); end
      vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL c1_idle_ready: got %b want 1", in_ready0); end
   endtask

   task automatic test_back_to_back();
      int acc_b = 0, out1 = 0, out2 = 0;
      logic [127:0] exp;
      @(negedge clk);
      in_data0 = C1_CT; in_key0 = C1_KEY; in_valid0 = 1'b1; out_ready0 = 1'b1;
      exp0_q.push_back(C1_PT);
      @(posedge clk); #1;
      in_data0 = B_CT; in_key0 = B_KEY;
      exp0_q.push_back(B_PT);
      for (int c = 1; c <= 40 && out2 == 0; c++) begin
         @(negedge clk);
         if (out_valid0 === 1'b1 && exp0_q.size() > 0) begin
            exp = exp0_q.pop_front();
            vectors++; if (out_data0 !== exp) begin miscompares++; $display("FAIL b2b_plaintext: got %h want %h", out_data0, exp); end
            if (out1 == 0) out1 = c; else out2 = c;
         end
         if (in_valid0 === 1'b1 && in_ready0 === 1'b1 && acc_b == 0) begin
            acc_b = c;
            @(posedge clk); #1; in_valid0 = 1'b0;
         end
      end
      exp0_q.delete();
      in_valid0 = 1'b0;
      vectors++; if (out1 !== 12) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 12", out1); end
      vectors++; if (acc_b !== 12) begin miscompares++; $display("FAIL b2b_second_accept: got %0d want 12", acc_b); end
      vectors++; if (out2 !== 24) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 24", out2); end
      @(negedge clk);
      vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid0); end
   endtask

   task automatic test_backpressure();
      int seen = 0;
      logic [127:0] exp;
      @(negedge clk);
      in_data0 = C1_CT; in_key0 = C1_KEY; in_valid0 = 1'b1; out_ready0 = 1'b0;
      exp0_q.push_back(C1_PT);
      @(posedge clk); #1; in_valid0 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid0 === 1'b1) break;
      end
      // an upstream offer during the stall must be ignored
      in_data0 = B_CT; in_key0 = B_KEY; in_valid0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         vectors++; if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL bp_valid_hold: got %b want 1", out_valid0); end
         vectors++; if (exp0_q.size() == 0 || out_data0 !== exp0_q[0]) begin miscompares++; $display("FAIL bp_data_hold: got %h want %h", out_data0, C1_PT); end
         vectors++; if (in_ready0 !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready0); end
         vectors++; if (round_cnt0 !== 4'd10) begin miscompares++; $display("FAIL bp_round_cnt: got %0d want 10", round_cnt0); end
      end
      @(negedge clk);
      in_valid0 = 1'b0; out_ready0 = 1'b1;
      if (exp0_q.size() > 0) begin
         exp = exp0_q.pop_front();
         vectors++; if (out_valid0 !== 1'b1 || out_data0 !== exp) begin miscompares++; $display("FAIL bp_release: got %b/%h want 1/%h", out_valid0, out_data0, exp); end
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid0 === 1'b1) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL bp_single_handshake: got %0d extra valid cycles want 0", seen); end
      vectors++; if (key_q0 !== C1_KEY) begin miscompares++; $display("FAIL bp_key_ignored: got %h want %h", key_q0, C1_KEY); end
   endtask

   task automatic test_flush();
      int found = 0, seen = 0;
      @(negedge clk);
      in_data0 = C1_CT; in_key0 = C1_KEY; in_valid0 = 1'b1; out_ready0 = 1'b1;
      @(posedge clk); #1; in_valid0 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (round_cnt0 === 4'd4) begin found = 1; break; end
      end
      vectors++; if (found !== 1) begin miscompares++; $display("FAIL flush_reach_r4: got %0d want 1", found); end
      flush0 = 1'b1;
      @(posedge clk); #1; flush0 = 1'b0;
      @(negedge clk);
      vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b want 1", in_ready0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b want 0", busy0); end
      vectors++; if (round_cnt0 !== 4'd0) begin miscompares++; $display("FAIL flush_round_cnt: got %0d want 0", round_cnt0); end
      vectors++; if (key_q0 !== C1_KEY) begin miscompares++; $display("FAIL flush_key_kept: got %h want %h", key_q0, C1_KEY); end
      // flush together with an accept discards the accept
      in_data0 = B_CT; in_key0 = B_KEY; in_valid0 = 1'b1; flush0 = 1'b1;
      @(posedge clk); #1; in_valid0 = 1'b0; flush0 = 1'b0;
      @(negedge clk);
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL flush_accept_busy: got %b want 0", busy0); end
      vectors++; if (key_q0 !== C1_KEY) begin miscompares++; $display("FAIL flush_accept_key: got %h want %h", key_q0, C1_KEY); end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid0 === 1'b1) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_reset_mid_round();
      int found = 0, seen = 0;
      @(negedge clk);
      in_data0 = C1_CT; in_key0 = C1_KEY; in_valid0 = 1'b1; out_ready0 = 1'b1;
      @(posedge clk); #1; in_valid0 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (round_cnt0 === 4'd5) begin found = 1; break; end
      end
      vectors++; if (found !== 1) begin miscompares++; $display("FAIL rst_reach_r5: got %0d want 1", found); end
      @(posedge clk); #2; rst_n = 1'b0; #1;
      vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy0); end
      vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready0); end
      vectors++; if (round_cnt0 !== 4'd0) begin miscompares++; $display("FAIL rst_mid_round_cnt: got %0d want 0", round_cnt0); end
      vectors++; if (out_data0 !== 128'h0) begin miscompares++; $display("FAIL rst_mid_out_data: got %h want 0", out_data0); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid0 === 1'b1) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_mid_no_valid: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_nr14();
      int lat;
      logic [127:0] exp;
      @(negedge clk);
      in_data1 = C3_CT; in_key1 = C3_KEY; in_valid1 = 1'b1; out_ready1 = 1'b1;
      exp1_q.push_back(C3_PT);
      @(posedge clk); #1; in_valid1 = 1'b0;
      lat = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); lat++;
         if (out_valid1 === 1'b1) break;
      end
      vectors++; if (lat !== 16) begin miscompares++; $display("FAIL nr14_latency: got %0d want 16", lat); end
      vectors++; if (round_cnt1 !== 4'd14) begin miscompares++; $display("FAIL nr14_round_cnt: got %0d want 14", round_cnt1); end
      if (out_valid1 === 1'b1 && exp1_q.size() > 0) begin
         exp = exp1_q.pop_front();
         vectors++; if (out_data1 !== exp) begin miscompares++; $display("FAIL nr14_plaintext: got %h want %h", out_data1, exp); end
      end
      exp1_q.delete();
      @(negedge clk);
      vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL nr14_valid_drop: got %b want 0", out_valid1); end
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_fips_c1();
      test_reset_mid_round();
      test_fips_c1();
      test_nr14();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aes_decrypt_iter_ctrl.md
Name: aes_decrypt_iter_ctrl

Overview:
Iterative AES inverse-cipher engine controller. It accepts one ciphertext block and key per valid/ready handshake and latches the key for the team's combinational Key_Expansion. It then reuses a single inverse-round datapath once per cycle for Nr rounds and presents the plaintext on an output valid/ready handshake. This replaces the fully unrolled decrypt datapath where area matters more than throughput.

Parameters:
Width, 128, key width in bits (128/192/256)
Nk, 4, key words (4/6/8), passed to Key_Expansion
Nr, 10, number of rounds (10/12/14)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext/key offered
in_ready  output  1  block can accept
in_data  input  128  ciphertext; byte 0 = [127:120]
in_key  input  Width  cipher key
key_q  output  Width  latched key; drives external Key_Expansion
word_in  input  128*(Nr+1)  round keys from Key_Expansion; slice k = word_in[128*k +: 128] is used at step k (decryption order)
out_valid  output  1  plaintext available
out_ready  input  1  consumer takes plaintext
out_data  output  128  plaintext (= state register)
flush  input  1  synchronous abort
busy  output  1  high in LOAD or ROUND
round_cnt  output  4  current round index

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state is flopped on rising clk; rst_n low clears immediately.
- Reset values:
  - FSM = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - round_cnt = 0; out_data = 0; key_q = 0; data_q = 0.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: data_q <= in_data, key_q <= in_key, go to LOAD.
- LOAD (1 cycle, lets word_in settle from the new key_q):
  - state_q <= data_q ^ word_in slice 0.
  - round_cnt <= 1; go to ROUND.
- ROUND, one round per cycle with r = round_cnt:
  - r < Nr: state_q <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_q)), slice r)); round_cnt <= r+1.
  - r == Nr: same step without InvMixColumns; go to DONE.
- DONE:
  - out_valid = 1; out_data and state_q are held stable until out_ready.
  - On out_ready: out_valid drops the next cycle, round_cnt <= 0.
  - in_ready = out_ready. A new accept in the same cycle goes directly to LOAD with no idle bubble.
- Latency: accept at cycle t gives out_valid high at cycle t+Nr+2 (12 cycles for Nr=10).
- Throughput: one block per Nr+2 cycles when out_ready is held high.
- in_valid outside IDLE/DONE is ignored (in_ready = 0); upstream holds its data.
- out_valid never drops without out_ready, except on flush or reset.
- flush has priority over all transitions:
  - Next cycle: FSM = IDLE, out_valid = 0, round_cnt = 0.
  - key_q and state_q are left unchanged (no zeroization).
  - A flush in the same cycle as an accept discards the accept.
- Reset mid-operation: all outputs return to reset values at once; no partial result is ever flagged valid.
- round_cnt width is fixed at 4 bits, with Nr <= 14 checked by elaboration assertion. It is 0 in IDLE/DONE-after-handshake and holds Nr in DONE.

Decomposition:
- Shared package aes_pkg:
  - constants AES_BLOCK = 128 and the Nr/Nk legal pairs.
  - FSM state enum dec_state_t {IDLE, LOAD, ROUND, DONE}.
  - function round_key_slice(word, k).
- One sub-module, aes_inv_round (combinational). It chains the existing Inv_Shift_Row, Inv_Sub_Bytes, addRoundKey and Inv_Mix_Colume. Input last_round bypasses InvMixColumns.
- Key_Expansion stays outside the controller, connected via key_q/word_in.

Test Plan:
- FIPS-197 C.1, AES-128: in_data 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f. Required: out_data 00112233445566778899aabbccddeeff, out_valid high exactly 12 cycles after accept.
- Back-to-back with out_ready held 1: two blocks with in_valid held high. Required: second accepted in the DONE cycle of the first, second out_valid 12 cycles later, both plaintexts correct.
- Backpressure with out_ready = 0 for 5 cycles in DONE. Required: out_valid/out_data stable, in_ready = 0, round_cnt = 10; release gives a single handshake.
- flush asserted at round_cnt = 4. Required: next cycle IDLE, in_ready = 1, out_valid never asserted. A fresh C.1 block afterwards decrypts correctly.
- rst_n pulsed low mid-ROUND (asynchronous, between edges). Required: out_valid = 0, busy = 0, in_ready = 1 immediately.
- Nr=14/Nk=8/Width=256, FIPS-197 C.3: ciphertext 8ea2b7ca516745bfeafc49904b496089. Required: plaintext 00112233445566778899aabbccddeeff after 16 cycles.
